// File: rtl/wb_stage.sv
// MEM/WB pipeline register, write-back mux, register-file strobes, read bypass and halt state.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module wb_stage #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [ADDR_W-1:0]   in_rd,
  input  logic                in_reg_write,
  input  logic [1:0]          in_wb_sel,
  input  logic [DATA_W-1:0]   in_alu,
  input  logic [DATA_W-1:0]   in_mem,
  input  logic [DATA_W-1:0]   in_pc2,
  input  logic                in_halt,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  input  logic [DATA_W-1:0]   rf_rd1,
  input  logic [DATA_W-1:0]   rf_rd2,
  output logic [DATA_W-1:0]   write_data,
  output logic [NUM_REGS-1:0] write_reg,
  output logic [ADDR_W-1:0]   wb_rd,
  output logic                wb_we,
  output logic [DATA_W-1:0]   byp_rd1,
  output logic [DATA_W-1:0]   byp_rd2,
  output logic                halt
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [15:0]         retired
`endif
);

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_PC2 = 2'd2;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        wb_sel;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [DATA_W-1:0] pc2;
    logic              halt;
  } stage_t;

  stage_t st;
  stage_t st_in;
  state_t state;
  logic   valid;
  logic   done;
  logic   halt_now;

  assign st_in = '{reg_write: in_reg_write, wb_sel: in_wb_sel, rd: in_rd,
                   alu: in_alu, mem: in_mem, pc2: in_pc2, halt: in_halt};

  // A retiring HLT in its first WB cycle; also kills whatever follows it in MEM.
  assign halt_now = valid & st.halt & ~done & (state == RUN);

  // Stage register and halt FSM; done marks a stalled instruction that already wrote.
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
      state <= RUN;
    end else begin
      if (halt_now) state <= HALTED;
      if (flush) begin
        valid <= 1'b0;
        done  <= 1'b0;
      end else if (stall) begin
        done <= valid;
      end else if ((state == HALTED) || halt_now) begin
        valid <= 1'b0;
      end else begin
        st    <= st_in;
        valid <= in_valid;
        done  <= 1'b0;
      end
    end
  end

  always_comb begin
    write_data = st.alu;
    case (st.wb_sel)
      SEL_MEM: write_data = st.mem;
      SEL_PC2: write_data = st.pc2;
      default: write_data = st.alu;
    endcase
  end

  assign wb_we = valid & st.reg_write & ~st.halt & ~done & (st.rd != '0) & (state == RUN);
  assign wb_rd = st.rd;
  assign halt  = (state == HALTED);

  always_comb begin
    write_reg = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      write_reg[i] = wb_we & (st.rd == ADDR_W'(i));
    end
  end

  // Same-cycle bypass; wb_we is never set for R0, so rs==0 reads the raw bitlines.
  assign byp_rd1 = (wb_we && (rs1 == st.rd)) ? write_data : rf_rd1;
  assign byp_rd2 = (wb_we && (rs2 == st.rd)) ? write_data : rf_rd2;

`ifdef WB_RETIRE_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= '0;
    end else if (valid && !done && (state == RUN)) begin
      retired <= retired + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed vector bench for wb_stage: table-driven sequence plus reset, stall and counter corners.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, in_reg_write, in_halt;
  logic [3:0]  in_rd, rs1, rs2;
  logic [1:0]  in_wb_sel;
  logic [15:0] in_alu, in_mem, in_pc2, rf_rd1, rf_rd2;
  logic [15:0] write_data, write_reg, byp_rd1, byp_rd2;
  logic [3:0]  wb_rd;
  logic        wb_we, halt;
`ifdef WB_RETIRE_COUNT_EN
  logic [15:0] retired;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_wb_sel(in_wb_sel), .in_alu(in_alu), .in_mem(in_mem), .in_pc2(in_pc2),
    .in_halt(in_halt), .rs1(rs1), .rs2(rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .write_data(write_data), .write_reg(write_reg), .wb_rd(wb_rd), .wb_we(wb_we),
    .byp_rd1(byp_rd1), .byp_rd2(byp_rd2), .halt(halt)
`ifdef WB_RETIRE_COUNT_EN
    , .retired(retired)
`endif
  );

  typedef struct {
    logic        v;
    logic [3:0]  rd;
    logic        rw;
    logic [1:0]  sel;
    logic [15:0] alu, mem, pc2;
    logic        hlt, stl, fl;
    logic [3:0]  rs1, rs2;
    logic [15:0] rf1, rf2;
    logic [15:0] e_wr, e_wd;
    logic        e_we;
    logic [3:0]  e_rd;
    logic [15:0] e_b1, e_b2;
    logic        e_halt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string nm, input int idx, input logic [15:0] got, input logic [15:0] exp);
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    in_valid = x.v; in_rd = x.rd; in_reg_write = x.rw; in_wb_sel = x.sel;
    in_alu = x.alu; in_mem = x.mem; in_pc2 = x.pc2; in_halt = x.hlt;
    stall = x.stl; flush = x.fl; rs1 = x.rs1; rs2 = x.rs2; rf_rd1 = x.rf1; rf_rd2 = x.rf2;
  endtask

  task automatic check_outs(input int idx, input vec_t x);
    nvec++;
    chk("write_reg",  idx, write_reg,        x.e_wr);
    chk("write_data", idx, write_data,       x.e_wd);
    chk("wb_we",      idx, 16'(wb_we),       16'(x.e_we));
    chk("wb_rd",      idx, 16'(wb_rd),       16'(x.e_rd));
    chk("byp_rd1",    idx, byp_rd1,          x.e_b1);
    chk("byp_rd2",    idx, byp_rd2,          x.e_b2);
    chk("halt",       idx, 16'(halt),        16'(x.e_halt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t h;

  initial begin
    //           v  rd rw sel alu       mem       pc2       hlt stl fl rs1 rs2 rf1       rf2        e_wr      e_wd      we rd  b1        b2        hlt
    vecs[0]  = '{1, 5, 1, 1, 16'h1111, 16'hBEEF, 16'h0002, 0, 0, 0, 5, 0, 16'hAAAA, 16'h0000, 16'h0020, 16'hBEEF, 1, 5, 16'hBEEF, 16'h0000, 0};
    vecs[1]  = '{1, 5, 1, 2, 16'h1111, 16'hBEEF, 16'h0102, 0, 0, 0, 0, 5, 16'h0000, 16'h3333, 16'h0020, 16'h0102, 1, 5, 16'h0000, 16'h0102, 0};
    vecs[2]  = '{1, 9, 1, 0, 16'h4242, 16'h0000, 16'h0000, 0, 0, 0, 1, 9, 16'h0011, 16'h0000, 16'h0200, 16'h4242, 1, 9, 16'h0011, 16'h4242, 0};
    vecs[3]  = '{1,15, 1, 3, 16'h8001, 16'h7777, 16'h6666, 0, 0, 0,15,14, 16'h0007, 16'h0E0E, 16'h8000, 16'h8001, 1,15, 16'h8001, 16'h0E0E, 0};
    vecs[4]  = '{1, 0, 1, 0, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 16'h0000, 16'h0000, 0};
    vecs[5]  = '{1, 4, 0, 0, 16'h0044, 16'h0000, 16'h0000, 0, 0, 0, 4, 4, 16'h1000, 16'h2000, 16'h0000, 16'h0044, 0, 4, 16'h1000, 16'h2000, 0};
    vecs[6]  = '{0, 8, 1, 0, 16'h0808, 16'h0000, 16'h0000, 0, 0, 0, 8, 0, 16'h0001, 16'h0000, 16'h0000, 16'h0808, 0, 8, 16'h0001, 16'h0000, 0};
    vecs[7]  = '{1, 7, 1, 0, 16'h1234, 16'h0000, 16'h0000, 0, 0, 0, 7, 2, 16'h0000, 16'h5555, 16'h0080, 16'h1234, 1, 7, 16'h1234, 16'h5555, 0};
    vecs[8]  = '{1, 3, 1, 0, 16'h0333, 16'h0000, 16'h0000, 0, 0, 0, 3, 0, 16'h0000, 16'h0000, 16'h0008, 16'h0333, 1, 3, 16'h0333, 16'h0000, 0};
    vecs[9]  = '{1,10, 1, 0, 16'hAAAA, 16'h0000, 16'h0000, 0, 1, 0, 3, 0, 16'h0003, 16'h0000, 16'h0000, 16'h0333, 0, 3, 16'h0003, 16'h0000, 0};
    vecs[10] = '{1,10, 1, 0, 16'hAAAA, 16'h0000, 16'h0000, 0, 1, 0, 3, 0, 16'h0003, 16'h0000, 16'h0000, 16'h0333, 0, 3, 16'h0003, 16'h0000, 0};
    vecs[11] = '{1,10, 1, 0, 16'hAAAA, 16'h0000, 16'h0000, 0, 1, 0, 3, 0, 16'h0003, 16'h0000, 16'h0000, 16'h0333, 0, 3, 16'h0003, 16'h0000, 0};
    vecs[12] = '{1, 6, 1, 0, 16'h0666, 16'h0000, 16'h0000, 0, 0, 0, 6, 0, 16'h0000, 16'h0000, 16'h0040, 16'h0666, 1, 6, 16'h0666, 16'h0000, 0};
    vecs[13] = '{1,11, 1, 0, 16'h0BBB, 16'h0000, 16'h0000, 0, 1, 1, 6, 0, 16'h0006, 16'h0000, 16'h0000, 16'h0666, 0, 6, 16'h0006, 16'h0000, 0};
    vecs[14] = '{1, 2, 1, 1, 16'h0000, 16'h2222, 16'h0000, 0, 0, 0, 2, 0, 16'h0000, 16'h0000, 16'h0004, 16'h2222, 1, 2, 16'h2222, 16'h0000, 0};
    vecs[15] = '{1, 4, 1, 0, 16'h4444, 16'h0000, 16'h0000, 1, 0, 0, 4, 0, 16'h0004, 16'h0000, 16'h0000, 16'h4444, 0, 4, 16'h0004, 16'h0000, 0};
    vecs[16] = '{1, 5, 1, 0, 16'h5555, 16'h0000, 16'h0000, 0, 0, 0, 4, 0, 16'h0004, 16'h0000, 16'h0000, 16'h4444, 0, 4, 16'h0004, 16'h0000, 1};
    vecs[17] = '{1, 5, 1, 0, 16'h5555, 16'h0000, 16'h0000, 0, 0, 0, 5, 0, 16'h0005, 16'h0000, 16'h0000, 16'h4444, 0, 4, 16'h0005, 16'h0000, 1};

    // Reset with a valid instruction presented; bypass passes bitlines through.
    h = '{1, 5, 1, 1, 16'h1111, 16'hBEEF, 16'h0002, 0, 0, 0, 3, 0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h1234, 16'h0000, 0};
    drive(h);
    rst = 1'b1;
    tick();
    check_outs(100, h);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      tick();
      check_outs(i, vecs[i]);
    end

    // Only reset leaves HALTED.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++;
    chk("halt_cleared", 101, 16'(halt), 16'h0000);
    chk("we_after_rst", 101, 16'(wb_we), 16'h0000);

    // Reset while a write is stalled in WB drops it.
    h = '{1, 3, 1, 0, 16'h0333, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0008, 16'h0333, 1, 3, 16'h0000, 16'h0000, 0};
    drive(h);
    tick();
    check_outs(102, h);
    stall = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall = 1'b0;
    in_valid = 1'b0;
    nvec++;
    chk("rst_stall_wr", 103, write_reg, 16'h0000);
    chk("rst_stall_we", 103, 16'(wb_we), 16'h0000);
    chk("rst_stall_wd", 103, write_data, 16'h0000);

`ifdef WB_RETIRE_COUNT_EN
    nvec++;
    chk("retired_rst", 104, retired, 16'h0000);
    // Two instructions, bubble, instruction, then idle: three retirements.
    in_reg_write = 1'b1;
    in_rd = 4'd1; in_valid = 1'b1; tick();
    in_rd = 4'd2; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    in_rd = 4'd3; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    tick();
    nvec++;
    chk("retired_cnt", 105, retired, 16'h0003);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register and write-back controller for the 16-bit WISC core.
- Latches the retiring instruction from MEM and selects the write-back value.
- Drives the register file's shared D bus and one-hot per-register WriteReg strobes.
- Provides same-cycle bypass for the two decode read ports, so a write and a read of the same register in one cycle return the new value.
- Owns the processor halt state.

Parameters:
- DATA_W, 16, datapath width
- ADDR_W, 4, register index width
- NUM_REGS, 16, number of architectural registers (2**ADDR_W); register 0 is hardwired zero

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold stage contents
- flush  in  1  load a bubble
- in_valid  in  1  MEM-stage instruction valid
- in_rd  in  ADDR_W  destination register
- in_reg_write  in  1  instruction writes a register
- in_wb_sel  in  2  0=ALU, 1=memory, 2=PC+2, 3=ALU
- in_alu  in  DATA_W  ALU result
- in_mem  in  DATA_W  load data
- in_pc2  in  DATA_W  PC+2 (for PCS)
- in_halt  in  1  instruction is HLT
- rs1, rs2  in  ADDR_W  decode read indices
- rf_rd1, rf_rd2  in  DATA_W  raw register-file bitline values
- write_data  out  DATA_W  D bus to all registers
- write_reg  out  NUM_REGS  one-hot write strobe
- wb_rd  out  ADDR_W  latched destination (for forwarding)
- wb_we  out  1  qualified write enable (for forwarding)
- byp_rd1, byp_rd2  out  DATA_W  bypassed read data
- halt  out  1  processor halted

Behaviour:
- Reset: all latched fields 0, valid=0, done=0, state=RUN.
  - Outputs after reset: write_reg=0, wb_we=0, write_data=0, wb_rd=0, halt=0.
  - byp_rd* pass rf_rd* through.
- Stage update at each clk edge, in priority order:
  - rst
  - flush: valid←0, done←0
  - stall: hold all fields; done←valid
  - state==HALTED: valid←0
  - otherwise: load in_* fields, valid←in_valid, done←0
- Write-back value is combinational from the latched fields, mux on wb_sel; sel 3 aliases ALU.
- wb_we = valid & reg_write & ~halt_fld & ~done & (rd≠0).
  - Each instruction writes exactly once, in its first WB cycle, even if stalled there for several cycles.
- write_reg[i] = wb_we & (rd==i). Bit 0 is never asserted.
- write_data is driven with the mux value every cycle. Registers capture it only on their strobe.
- Bypass: byp_rdN = (wb_we & rsN==wb_rd) ? write_data : rf_rdN.
  - rsN==0 always yields rf_rdN, which is 0.
- Latency: an instruction presented with in_valid at edge k gets its strobe during cycle k..k+1. The register updates at edge k+1.
- FSM states: RUN, HALTED.
  - RUN→HALTED at the edge after a cycle with valid & halt_fld & ~done.
  - HALTED is left only by rst.
  - halt = (state==HALTED).
  - An HLT instruction never writes a register.
  - In HALTED, inputs are ignored and no further strobes are issued.
- Simultaneous flush+stall: flush wins.
- Reset during a stalled write: the pending strobe is dropped; no write occurs after the rst edge.

Optional Feature:
- Macro: WB_RETIRE_COUNT_EN.
- When defined:
  - Adds output retired (16 bits), reset to 0.
  - Increments once per instruction on the edge that ends its first WB cycle, i.e. valid & ~done.
  - Counts HLT and non-writing instructions.
  - Wraps 0xFFFF→0x0000.
  - Frozen in HALTED.
- When not defined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst with in_valid=1 → all outputs 0 and halt=0 on the first cycle after the rst edge.
- Write select: in_rd=5, reg_write=1, sel=1, in_mem=0xBEEF → next cycle write_reg=0x0020, write_data=0xBEEF, wb_we=1. Repeat with sel=2, in_pc2=0x0102 → write_data=0x0102.
- R0 and stall:
  - in_rd=0, reg_write=1 → write_reg=0, wb_we=0.
  - in_rd=3 followed by 3 stall cycles → write_reg=0x0008 in exactly one cycle.
- Bypass: WB writes R7=0x1234 while rs1=7, rf_rd1=0x0000, rs2=2, rf_rd2=0x5555 → byp_rd1=0x1234, byp_rd2=0x5555.
- Halt: HLT with reg_write=1, rd=4 → no strobe; halt=1 from the next edge. Subsequent valid writes are ignored until rst.
- Flush and counter:
  - flush together with stall while holding rd=6 → bubble, no strobe.
  - With WB_RETIRE_COUNT_EN, 3 valid instructions plus 1 bubble → retired=3.
